aes_round_ctrl: RTL
===================

# aes_round_ctrl

Iterative AES-128 encryption sequencer. It accepts one plaintext/key pair over a valid/ready handshake and applies the initial AddRoundKey. It then steps an external combinational round datapath (SubBytes → ShiftRows → [MixColumns] → AddRoundKey) through rounds 1..10, one round per clock, expanding round keys on the fly through an external SubWord S-box, and returns the ciphertext over a second valid/ready handshake. It sits between the UART framing logic and the round datapath.

## Interface
Parameters:
- NR, 10, number of rounds; fixed for AES-128, other values unsupported.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext/key pair available.
- in_ready  out  1  block accepts a new pair.
- in_pt  in  128  plaintext; byte 0 in [127:120], column c in [127-32c -: 32].
- in_key  in  128  cipher key; same byte ordering.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_ct  out  128  ciphertext.
- dp_state  out  128  state presented to round datapath.
- dp_key  out  128  round key for current round.
- dp_final  out  1  high in round NR; datapath must skip MixColumns.
- dp_result  in  128  combinational datapath result.
- sw_in  out  32  RotWord of key word 3: {key_reg[23:0], key_reg[31:24]}.
- sw_out  in  32  combinational SubWord(sw_in).

## Operation
- FSM states: IDLE, ROUND, DONE. Registers: state_reg[127:0], key_reg[127:0], rnd[3:0].
- IDLE: in_ready=1. On in_valid&in_ready: state_reg←in_pt^in_key, key_reg←in_key, rnd←1, go to ROUND.
- Key step (combinational): t = sw_out ^ {rcon[rnd],24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2', with w0=key_reg[127:96] .. w3=key_reg[31:0]. next_key={w0',w1',w2',w3'}.
- rcon for rnd 1..10: 01,02,04,08,10,20,40,80,1B,36.
- ROUND: dp_state=state_reg, dp_key=next_key, dp_final=(rnd==NR). Each cycle: state_reg←dp_result, key_reg←next_key, rnd←rnd+1. When rnd==NR: go to DONE instead of incrementing.
- DONE: out_valid=1, out_ct=state_reg, both held stable until out_ready. On out_valid&out_ready: go to IDLE.
- Outside ROUND: dp_key=0, dp_final=0, dp_state=state_reg. sw_in always derived from key_reg.
- in_ready=0 in ROUND and DONE, except as allowed under Configuration. in_valid outside IDLE is ignored; the pair is not captured.
- rst asserted at any time, including mid-round or in DONE: FSM→IDLE, all registers cleared, the in-flight block is discarded and no out_valid pulse is produced.

## Timing
- Values on reset: in_ready=1, out_valid=0, out_ct=0, dp_state=0, dp_key=0, dp_final=0, sw_in=0.
- Accept at edge E0. Rounds 1..10 are captured at edges E1..E10. out_valid is high from E10 to the handshake edge.
- Latency from accept edge to first out_valid cycle: 10 cycles. Minimum spacing between accepts: 12 cycles (11 with back-to-back).
- dp_result and sw_out are sampled in the same cycle they are driven. The external paths must be purely combinational and meet a single-cycle path.
- out_ready held low stalls indefinitely in DONE with outputs stable.

## Configuration
- AES_BACK_TO_BACK_EN defined: in DONE, in_ready=out_ready. A simultaneous output and input handshake loads the new pair and goes directly to ROUND. out_valid drops for exactly the ROUND cycles.
- Undefined: in_ready=1 only in IDLE; one idle cycle always separates blocks.

## Test plan
Bench supplies reference SubBytes/ShiftRows/MixColumns/AddRoundKey and S-box models.
- FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → out_ct 3925841d02dc09fbdc118597196a0b32, out_valid first high 10 cycles after accept; dp_key in round 1 = a0fafe1788542cb123a339392a6c7605.
- FIPS-197 App. C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a. dp_final high only in round 10.
- Backpressure: out_ready low for 20 cycles → out_valid/out_ct stable, in_ready=0, and an in_valid pulse is not captured. Release → one handshake, then IDLE.
- Reset mid-operation: assert rst during round 5 → out_valid=0, in_ready=1, state cleared. Next App. B vector gives the correct ciphertext.
- Back-to-back with AES_BACK_TO_BACK_EN: two App. B/C.1 blocks with in_valid and out_ready held high → accepts exactly 11 cycles apart, both ciphertexts correct. Without the macro → 12 cycles apart.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 round sequencer with on-the-fly key expansion
// Optional AES_BACK_TO_BACK_EN: accept the next block during the DONE output handshake.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic         dp_final,
  input  logic [127:0] dp_result,
  output logic [31:0]  sw_in,
  input  logic [31:0]  sw_out
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [7:0]   rcon;
  logic [31:0]  t, w0, w1, w2, w3;
  logic [127:0] next_key;
  logic         last_rnd;
  logic         accept;

  always_comb begin
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Key schedule step: external S-box supplies SubWord(RotWord(w3))
  always_comb begin
    t  = sw_out ^ {rcon, 24'h0};
    w0 = key_q[127:96] ^ t;
    w1 = key_q[95:64]  ^ w0;
    w2 = key_q[63:32]  ^ w1;
    w3 = key_q[31:0]   ^ w2;
  end

  assign next_key = {w0, w1, w2, w3};
  assign sw_in    = {key_q[23:0], key_q[31:24]};
  assign last_rnd = (rnd_q == 4'(NR));
  assign dp_state = state_q;
  assign out_ct   = state_q;

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    key_d     = key_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dp_key    = '0;
    dp_final  = 1'b0;
    accept    = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      ROUND: begin
        dp_key   = next_key;
        dp_final = last_rnd;
        state_d  = dp_result;
        key_d    = next_key;
        if (last_rnd) begin
          fsm_d = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef AES_BACK_TO_BACK_EN
        in_ready  = out_ready;
        accept    = in_valid & out_ready;
`endif
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
    // A new pair always wins, including the back-to-back handoff out of DONE
    if (accept) begin
      state_d = in_pt ^ in_key;
      key_d   = in_key;
      rnd_d   = 4'd1;
      fsm_d   = ROUND;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule
